// File: rtl/pwm_ctrl_pkg.sv
// Shared register map and ramp FSM encoding for the PWM output control block.
package pwm_ctrl_pkg;

  localparam int ADDR_UO      = 0;
  localparam int ADDR_UIO     = 1;
  localparam int ADDR_PWM_UO  = 2;
  localparam int ADDR_PWM_UIO = 3;
  localparam int ADDR_DUTY    = 4;

  localparam int NUM_REGS = 5;

  typedef logic [1:0] ramp_state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TICK = 2'd1;
  localparam logic [1:0] ST_STEP      = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..TICK_DIV-1 while clr is low and flags the terminal count.
module ramp_tick_gen #(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == TERM)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = !clr && (cnt_q == TERM);

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Output/PWM register bank shared between SPI host writes and a timed duty-cycle ramp engine.
module pwm_ramp_scheduler
  import pwm_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = pwm_ctrl_pkg::NUM_REGS,
  parameter int TICK_DIV = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              ramp_start,
  input  logic              ramp_stop,
  input  logic [DATA_W-1:0] ramp_target,
  input  logic [DATA_W-1:0] ramp_step,
  output logic [DATA_W-1:0] reg_uo_out,
  output logic [DATA_W-1:0] reg_uio_out,
  output logic [DATA_W-1:0] reg_pwm_uo,
  output logic [DATA_W-1:0] reg_pwm_uio,
  output logic [DATA_W-1:0] reg_duty,
  output logic              ramp_busy,
  output logic              ramp_done,
  output logic              ramp_abort
);

  // Handshake: spi_wr_valid, ramp_start and ramp_stop are single-cycle strobes with no
  // back-pressure; each is consumed on the clock edge where it is high or dropped.

  ramp_state_t       state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] tgt_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] step_duty;
  logic [DATA_W:0]   up_sum;
  logic [DATA_W:0]   dn_diff;
  logic              duty_wr;
  logic              busy;
  logic              abort_req;
  logic              start_ok;
  logic              step_commit;
  logic              tick;

  assign duty_wr     = spi_wr_valid && (spi_wr_addr == ADDR_W'(ADDR_DUTY));
  assign busy        = (state_q != ST_IDLE);
  assign abort_req   = busy && (duty_wr || ramp_stop);
  assign start_ok    = !busy && ramp_start && !ramp_stop;
  assign step_commit = (state_q == ST_STEP) && !abort_req;

  ramp_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != ST_WAIT_TICK),
    .tick (tick)
  );

  // One extra bit catches carry past the top and borrow past zero before clamping to target.
  always_comb begin
    up_sum    = {1'b0, regs_q[ADDR_DUTY]} + {1'b0, step_q};
    dn_diff   = {1'b0, regs_q[ADDR_DUTY]} - {1'b0, step_q};
    step_duty = tgt_q;
    if (tgt_q > regs_q[ADDR_DUTY]) begin
      if (up_sum < {1'b0, tgt_q}) step_duty = up_sum[DATA_W-1:0];
    end else begin
      if (!dn_diff[DATA_W] && (dn_diff[DATA_W-1:0] > tgt_q)) step_duty = dn_diff[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) state_d = (ramp_target == regs_q[ADDR_DUTY]) ? ST_DONE : ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (tick) state_d = ST_STEP;
        end
        ST_STEP: begin
          state_d = (step_duty == tgt_q) ? ST_DONE : ST_WAIT_TICK;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        tgt_q  <= ramp_target;
        step_q <= (ramp_step == '0) ? DATA_W'(1) : ramp_step;
      end
    end
  end

  // SPI writes land unconditionally; the ramp only commits a step when no abort is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (spi_wr_valid && (spi_wr_addr == ADDR_W'(i))) regs_q[i] <= spi_wr_data;
      end
      if (step_commit) regs_q[ADDR_DUTY] <= step_duty;
    end
  end

  assign reg_uo_out  = regs_q[ADDR_UO];
  assign reg_uio_out = regs_q[ADDR_UIO];
  assign reg_pwm_uo  = regs_q[ADDR_PWM_UO];
  assign reg_pwm_uio = regs_q[ADDR_PWM_UIO];
  assign reg_duty    = regs_q[ADDR_DUTY];
  assign ramp_busy   = busy;
  assign ramp_done   = (state_q == ST_DONE) && !abort_req;
  assign ramp_abort  = abort_req;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Event-scoreboard bench for pwm_ramp_scheduler: every output change is matched, in cycle order, against a model queue.
module tb_pwm_ramp_scheduler;

  localparam int TD        = 4;
  localparam int PER       = TD + 1;
  localparam int W         = 32;
  localparam int TAG_BUSY  = 5;
  localparam int TAG_DONE  = 6;
  localparam int TAG_ABORT = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_wr_valid;
  logic [6:0] spi_wr_addr;
  logic [7:0] spi_wr_data;
  logic       ramp_start;
  logic       ramp_stop;
  logic [7:0] ramp_target;
  logic [7:0] ramp_step;
  logic [7:0] reg_uo_out, reg_uio_out, reg_pwm_uo, reg_pwm_uio, reg_duty;
  logic       ramp_busy, ramp_done, ramp_abort;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [W-1:0] exp_q[$];
  int         m_regs[5];
  logic       mon_en = 1'b0;
  logic [7:0] prev_regs[5];
  logic       prev_busy;

  pwm_ramp_scheduler #(
    .ADDR_W  (7),
    .DATA_W  (8),
    .NUM_REGS(5),
    .TICK_DIV(TD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_wr_valid(spi_wr_valid),
    .spi_wr_addr (spi_wr_addr),
    .spi_wr_data (spi_wr_data),
    .ramp_start  (ramp_start),
    .ramp_stop   (ramp_stop),
    .ramp_target (ramp_target),
    .ramp_step   (ramp_step),
    .reg_uo_out  (reg_uo_out),
    .reg_uio_out (reg_uio_out),
    .reg_pwm_uo  (reg_pwm_uo),
    .reg_pwm_uio (reg_pwm_uio),
    .reg_duty    (reg_duty),
    .ramp_busy   (ramp_busy),
    .ramp_done   (ramp_done),
    .ramp_abort  (ramp_abort)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard helpers ----------------
  // Event word: {stamp[19:0], tag[3:0], data[7:0]}; tags 0..4 are registers.
  function automatic logic [W-1:0] ev(input int stamp, input int tag, input int data);
    logic [19:0] s;
    logic [3:0]  t;
    logic [7:0]  d;
    s = stamp[19:0];
    t = tag[3:0];
    d = data[7:0];
    return {s, t, d};
  endfunction

  task automatic push_ev(input logic [W-1:0] e);
    int i;
    i = 0;
    while (i < exp_q.size() && exp_q[i] <= e) i++;
    exp_q.insert(i, e);
  endtask

  task automatic plan(input int stamp, input int tag, input int data, input int lim);
    if (stamp <= lim) push_ev(ev(stamp, tag, data));
  endtask

  task automatic drop_from(input int s);
    logic [W-1:0] keep[$];
    foreach (exp_q[i]) if (int'(exp_q[i][31:12]) < s) keep.push_back(exp_q[i]);
    exp_q = keep;
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic observe(input logic [W-1:0] got);
    logic [W-1:0] want;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got cycle=%0d tag=%0d data=%0h, required no event",
               got[31:12], got[11:8], got[7:0]);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_fail++;
        $display("FAIL event_match: got cycle=%0d tag=%0d data=%0h, required cycle=%0d tag=%0d data=%0h",
                 got[31:12], got[11:8], got[7:0], want[31:12], want[11:8], want[7:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [7:0] cur[5];
    if (mon_en) begin
      cur[0] = reg_uo_out;
      cur[1] = reg_uio_out;
      cur[2] = reg_pwm_uo;
      cur[3] = reg_pwm_uio;
      cur[4] = reg_duty;
      for (int i = 0; i < 5; i++) if (cur[i] !== prev_regs[i]) observe(ev(cyc, i, int'(cur[i])));
      if (ramp_busy !== prev_busy) observe(ev(cyc, TAG_BUSY, int'(ramp_busy)));
      if (ramp_done !== 1'b0) observe(ev(cyc, TAG_DONE, 1));
      if (ramp_abort !== 1'b0) observe(ev(cyc, TAG_ABORT, 1));
      prev_regs = cur;
      prev_busy = ramp_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    int g;
    g = 0;
    while (cyc < c && g < 5000) begin
      next_cycle();
      g++;
    end
  endtask

  task automatic spi_write(input int a, input int d);
    spi_wr_valid = 1'b1;
    spi_wr_addr  = a[6:0];
    spi_wr_data  = d[7:0];
    if (a < 5) begin
      if (m_regs[a] != d) push_ev(ev(cyc + 1, a, d));
      m_regs[a] = d;
    end
    next_cycle();
    spi_wr_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      next_cycle();
      g++;
    end
    check_eq(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) next_cycle();
  endtask

  // mode 0: run to completion; 1: SPI duty write on STEP cycle of step k; 2: ramp_stop in WAIT of step k;
  // 3: addr-0 write and a retarget attempt mid-ramp; 4: reset in WAIT of step k.
  task automatic ramp(input int t, input int s, input int mode, input int k_sel, input int aux);
    int d, se, x, k, n, lim, c_ev, held, nv;
    int vals[$];
    logic [7:0] tt;
    d  = m_regs[4];
    se = (s == 0) ? 1 : s;
    x  = d;
    while (x != t) begin
      if (t > x) x = (x + se > t) ? t : x + se;
      else       x = (x - se < t) ? t : x - se;
      vals.push_back(x);
    end
    nv = vals.size();
    k  = (k_sel < 1) ? 1 : k_sel;
    if (k > nv) k = nv;
    held = d;
    if (k >= 2) held = vals[k-2];
    n = cyc + 1;
    case (mode)
      1:       c_ev = n + k * PER - 1;
      2:       c_ev = n + (k - 1) * PER + 1;
      4:       c_ev = n + (k - 1) * PER + 2;
      default: c_ev = 0;
    endcase
    if (mode == 1 || mode == 2) lim = c_ev;
    else if (mode == 4)         lim = c_ev - 1;
    else                        lim = 1 << 30;

    plan(n, TAG_BUSY, 1, lim);
    for (int j = 1; j <= nv; j++) plan(n + j * PER, 4, vals[j-1], lim);
    plan(n + nv * PER, TAG_DONE, 1, lim);
    plan(n + nv * PER + 1, TAG_BUSY, 0, lim);

    ramp_start  = 1'b1;
    ramp_target = t[7:0];
    ramp_step   = s[7:0];
    next_cycle();
    ramp_start  = 1'b0;
    ramp_target = 8'($urandom);
    ramp_step   = 8'($urandom);

    case (mode)
      1: begin
        wait_until(c_ev);
        spi_wr_valid = 1'b1;
        spi_wr_addr  = 7'd4;
        spi_wr_data  = aux[7:0];
        push_ev(ev(c_ev, TAG_ABORT, 1));
        if (aux != held) push_ev(ev(c_ev + 1, 4, aux));
        push_ev(ev(c_ev + 1, TAG_BUSY, 0));
        next_cycle();
        spi_wr_valid = 1'b0;
        m_regs[4] = aux;
      end
      2: begin
        wait_until(c_ev);
        ramp_stop = 1'b1;
        push_ev(ev(c_ev, TAG_ABORT, 1));
        push_ev(ev(c_ev + 1, TAG_BUSY, 0));
        next_cycle();
        ramp_stop = 1'b0;
        m_regs[4] = held;
      end
      3: begin
        wait_until(n + 2);
        spi_write(0, aux);
        tt = t[7:0];
        ramp_start  = 1'b1;
        ramp_target = ~tt;
        ramp_step   = 8'hFF;
        next_cycle();
        ramp_start = 1'b0;
        m_regs[4] = t;
      end
      4: begin
        wait_until(c_ev);
        rst_n = 1'b0;
        #1;
        check_eq("reset_mid_regs", {reg_uo_out, reg_uio_out, reg_pwm_uo, reg_pwm_uio}, 32'h0);
        check_eq("reset_mid_duty_flags", {21'h0, reg_duty, ramp_busy, ramp_done, ramp_abort}, 32'h0);
        drop_from(c_ev);
        for (int i = 0; i < 4; i++) if (m_regs[i] != 0) push_ev(ev(c_ev, i, 0));
        if (held != 0) push_ev(ev(c_ev, 4, 0));
        push_ev(ev(c_ev, TAG_BUSY, 0));
        for (int i = 0; i < 5; i++) m_regs[i] = 0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
      end
      default: m_regs[4] = t;
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd, rt, rs, rm;
    rst_n        = 1'b1;
    spi_wr_valid = 1'b0;
    spi_wr_addr  = '0;
    spi_wr_data  = '0;
    ramp_start   = 1'b0;
    ramp_stop    = 1'b0;
    ramp_target  = '0;
    ramp_step    = '0;
    for (int i = 0; i < 5; i++) begin
      m_regs[i]    = 0;
      prev_regs[i] = 8'h00;
    end
    prev_busy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_uo", reg_uo_out, 0);
    check_eq("reset_uio", reg_uio_out, 0);
    check_eq("reset_pwm_uo", reg_pwm_uo, 0);
    check_eq("reset_pwm_uio", reg_pwm_uio, 0);
    check_eq("reset_duty", reg_duty, 0);
    check_eq("reset_busy", ramp_busy, 0);
    check_eq("reset_done", ramp_done, 0);
    check_eq("reset_abort", ramp_abort, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    next_cycle();

    // Register writes, including an unimplemented address.
    spi_write(0, 'hF0);
    spi_write(1, 'h0F);
    spi_write(4, 'h80);
    spi_write(7, 'hAA);
    next_cycle();
    check_eq("t1_uo", reg_uo_out, 'hF0);
    check_eq("t1_uio", reg_uio_out, 'h0F);
    check_eq("t1_pwm_uo", reg_pwm_uo, 'h00);
    check_eq("t1_pwm_uio", reg_pwm_uio, 'h00);
    check_eq("t1_duty", reg_duty, 'h80);
    check_eq("t1_busy", ramp_busy, 0);
    drain("t1_drain");

    // Upward ramp 10 -> 20 by 5.
    spi_write(4, 'h10);
    ramp('h20, 5, 0, 0, 0);
    drain("t2_drain");
    check_eq("t2_final", reg_duty, 'h20);

    // Saturation at both ends of the range.
    spi_write(4, 'h05);
    ramp('h00, 8, 0, 0, 0);
    drain("t3_down_drain");
    check_eq("t3_down_final", reg_duty, 'h00);
    spi_write(4, 'hFA);
    ramp('hFF, 'h10, 0, 0, 0);
    drain("t3_up_drain");
    check_eq("t3_up_final", reg_duty, 'hFF);

    // SPI duty write coincident with the second STEP cycle.
    spi_write(4, 'h10);
    ramp('h40, 4, 1, 2, 'h55);
    drain("t4_abort_drain");
    check_eq("t4_duty", reg_duty, 'h55);
    check_eq("t4_busy", ramp_busy, 0);
    ramp('h90, 'h20, 3, 0, 'h3C);
    drain("t4_addr0_drain");
    check_eq("t4_addr0_final", reg_duty, 'h90);

    // ramp_stop mid-ramp, target equal to duty, stop in IDLE, stop+start together.
    ramp('h10, 'h10, 2, 2, 0);
    drain("t5_stop_drain");
    check_eq("t5_stop_frozen", reg_duty, 'h80);
    ramp('h80, 3, 0, 0, 0);
    drain("t5_equal_drain");
    check_eq("t5_equal_duty", reg_duty, 'h80);
    ramp_stop = 1'b1;
    next_cycle();
    ramp_start  = 1'b1;
    ramp_target = 8'h00;
    ramp_step   = 8'h01;
    next_cycle();
    ramp_stop  = 1'b0;
    ramp_start = 1'b0;
    repeat (3) next_cycle();
    check_eq("t5_idle_stop_busy", ramp_busy, 0);
    check_eq("t5_idle_stop_duty", reg_duty, 'h80);

    // Reset mid-ramp, then a fresh ramp from zero.
    spi_write(4, 'h30);
    ramp('h90, 8, 4, 3, 0);
    drain("t6_reset_drain");
    ramp('h18, 6, 0, 0, 0);
    drain("t6_after_drain");
    check_eq("t6_after_final", reg_duty, 'h18);

    // Randomized ramps with random interruptions.
    for (int it = 0; it < 10; it++) begin
      rd = int'($urandom_range(0, 255));
      rt = int'($urandom_range(0, 255));
      rs = int'($urandom_range(0, 48));
      rm = int'($urandom_range(0, 3));
      if (rt == rd && rm != 0) rt = (rd + 1) % 256;
      spi_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      spi_write(int'($urandom_range(5, 127)), int'($urandom_range(0, 255)));
      spi_write(4, rd);
      ramp(rt, rs, rm, int'($urandom_range(1, 4)), int'($urandom_range(0, 255)));
      drain("rand_drain");
      check_eq("rand_final_duty", reg_duty, m_regs[4]);
    end

    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
